// File: rtl/mult65_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult65_accum_pkg
// Brief  : Constants shared between the mult65 instantiation and its
//          accumulator, plus the pipeline tag type that tracks each beat.
// Rev    : 1.0  initial release
// ============================================================================
package mult65_accum_pkg;

  // Product width of the 65x65 multiplier.
  localparam int PROD_W     = 130;
  // Term counter width; a legal group holds at most 2**CNT_W terms.
  localparam int CNT_W      = 8;
  // Accumulator width, large enough that legal groups never wrap.
  localparam int ACC_W      = PROD_W + CNT_W;
  // Operand-to-product latency of the built multiplier.
  localparam int MULT_LAT   = 3;
  // Finished-sum buffer entries.
  localparam int FIFO_DEPTH = 2;

  // Tag carried alongside each operand pair while mult65 works on it.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage : mult65_accum_pkg
`default_nettype wire

// File: rtl/acc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : acc_sync_fifo
// Brief  : Parameterized synchronous FIFO with occupancy count. Head data is
//          presented combinationally; storage is cleared on reset so an empty
//          head reads as zero.
// Rev    : 1.0  initial release
// ============================================================================
module acc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == c_depth);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage write; cleared on reset so the idle head drives zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule : acc_sync_fifo
`default_nettype wire

// File: rtl/mult65_accum.sv
`default_nettype none
// ============================================================================
// Module : mult65_accum
// Brief  : Multiply-accumulate back end for mult65. Tracks each issued beat
//          through a tag delay line matched to multiplier latency, sums the
//          products of a group, and queues finished sums behind a
//          valid/ready handshake. Operand issue is credit-throttled so a
//          finished sum always finds room in the output buffer.
// Rev    : 1.0  initial release
// ============================================================================
module mult65_accum
  import mult65_accum_pkg::*;
#(
  parameter int PROD_W     = mult65_accum_pkg::PROD_W,
  parameter int CNT_W      = mult65_accum_pkg::CNT_W,
  parameter int ACC_W      = PROD_W + CNT_W,
  parameter int MULT_LAT   = mult65_accum_pkg::MULT_LAT,
  parameter int FIFO_DEPTH = mult65_accum_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W:0]    out_count,
  output logic              out_ovf
);

  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int RES_W = ACC_W + CNT_W + 1 + 1;
  localparam logic [CNT_W:0] c_cnt_max = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] c_cnt_one = (CNT_W+1)'(1);
  localparam logic [FC_W:0]  c_depth   = (FC_W+1)'(FIFO_DEPTH);

  // Tag delay line; the last stage lines up with the product on prod.
  tag_t r_tag [MULT_LAT];
  tag_t w_tag_in;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W:0]   r_cnt;
  logic             r_first;
  logic             r_ovf;
  logic [FC_W-1:0]  r_pend;

  logic             w_accept;
  logic             w_d_valid;
  logic             w_d_last;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_nsum;
  logic [CNT_W:0]   w_ncnt;
  logic             w_novf;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_empty;
  logic [FC_W-1:0]  w_fifo_count;
  logic [FC_W:0]    w_outstanding;
  logic [RES_W-1:0] w_push_data;
  logic [RES_W-1:0] w_head;

  assign w_accept   = in_valid && in_ready;
  assign w_tag_in   = '{valid: w_accept, last: w_accept && in_last};
  assign w_d_valid  = r_tag[MULT_LAT-1].valid;
  assign w_d_last   = r_tag[MULT_LAT-1].last;

  assign w_prod_ext = ACC_W'(prod);
  assign w_nsum     = r_first ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_ncnt     = r_first ? c_cnt_one  : (r_cnt + c_cnt_one);
  // Overflow latches once a term arrives while the count already sits at 2**CNT_W.
  assign w_novf     = r_first ? 1'b0 : (r_ovf || (r_cnt == c_cnt_max));

  assign w_push     = w_d_valid && w_d_last;
  assign w_pop      = out_valid && out_ready;

  // Every accepted last owns a buffer slot from acceptance until it is popped,
  // so a push can never meet a full buffer.
  assign w_outstanding = {1'b0, w_fifo_count} + {1'b0, r_pend};
  assign in_ready      = (w_outstanding < c_depth);

  // Shift accepted-beat tags toward the product; reset drops in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < MULT_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Running sum, term count and overflow flag of the open group.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_ovf   <= 1'b0;
    end else if (w_d_valid) begin
      if (w_d_last) begin
        r_first <= 1'b1;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_acc   <= w_nsum;
        r_cnt   <= w_ncnt;
        r_first <= 1'b0;
        r_ovf   <= w_novf;
      end
    end
  end

  // Lasts accepted whose group sum has not yet reached the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      unique case ({w_accept && in_last, w_push})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  assign w_push_data = {w_nsum, w_ncnt, w_novf};

  acc_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;
  assign {out_sum, out_count, out_ovf} = w_head;

endmodule : mult65_accum
`default_nettype wire

// File: tb/tb_mult65_accum.sv
`default_nettype none
// ============================================================================
// Module : tb_mult65_accum
// Brief  : Self-checking bench for mult65_accum. A behavioural mult65 stand-in
//          feeds prod; a group-level scoreboard predicts every popped sum and
//          the credit state from observed handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mult65_accum;
  import mult65_accum_pkg::*;

  localparam int LAT   = mult65_accum_pkg::MULT_LAT;
  localparam int DEPTH = mult65_accum_pkg::FIFO_DEPTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [129:0] prod;
  logic         out_valid;
  logic         out_ready;
  logic [137:0] out_sum;
  logic [8:0]   out_count;
  logic         out_ovf;

  logic [64:0]  tb_a;
  logic [64:0]  tb_b;
  logic         rand_en;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult65_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Stand-in multiplier: product of the operands driven LAT cycles earlier; never reset.
  logic [129:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 130'(tb_a) * 130'(tb_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign prod = mpipe[LAT-1];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Group-level reference: sums built from the operands at each accepted beat.
  typedef struct {
    logic [137:0] sum;
    logic [8:0]   cnt;
    logic         ovf;
  } exp_t;
  exp_t         q[$];
  logic [137:0] m_acc;
  int           m_cnt;
  int           m_out;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_acc = '0;
      m_cnt = 0;
      m_out = 0;
    end else begin
      chk("in_ready", in_ready, (m_out < DEPTH));
      if (q.size() == 0) chk("no_stray_out", out_valid, 1'b0);
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_sum", out_sum, e.sum);
        chk("sb_count", out_count, e.cnt);
        chk("sb_ovf", out_ovf, e.ovf);
        m_out--;
      end
      if (in_valid && in_ready) begin
        m_acc = m_acc + 138'(tb_a) * 138'(tb_b);
        m_cnt++;
        if (in_last) begin
          e.sum = m_acc;
          e.cnt = 9'(m_cnt);
          e.ovf = (m_cnt > 256);
          q.push_back(e);
          m_acc = '0;
          m_cnt = 0;
          m_out++;
        end
      end
    end
  end

  // Random consumer stalls during the randomized phase.
  always @(posedge clk) begin
    #1;
    if (rand_en) out_ready = ($urandom_range(0, 2) != 0);
  end

  // All driving tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [64:0] a, input logic [64:0] b, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    tb_a     = a;
    tb_b     = b;
    in_last  = last;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("issue_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_head(input string nm, input logic [137:0] s, input logic [8:0] c,
                             input logic o);
    bit seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk({nm, "_seen"}, seen, 1'b1);
    if (seen) begin
      chk({nm, "_sum"}, out_sum, s);
      chk({nm, "_count"}, out_count, c);
      chk({nm, "_ovf"}, out_ovf, o);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [64:0]  a;
    logic [64:0]  b;
    logic [137:0] exp_sum;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [137:0] ones_sq;
    logic [64:0]  ra;
    logic [64:0]  rb;

    ones_sq = (138'(1) << 130) - (138'(1) << 66) + 138'(1);
    tbl[0] = '{a: 65'd3,        b: 65'd5,        exp_sum: 138'd15};
    tbl[1] = '{a: 65'd0,        b: '1,           exp_sum: 138'd0};
    tbl[2] = '{a: 65'd1,        b: 65'd1,        exp_sum: 138'd1};
    tbl[3] = '{a: '1,           b: '1,           exp_sum: ones_sq};
    tbl[4] = '{a: 65'd1 << 64,  b: 65'd2,        exp_sum: 138'd1 << 65};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tb_a      = '0;
    tb_b      = '0;
    rand_en   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 138'd0);
    chk("rst_out_count", out_count, 9'd0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency of a single-term group: valid exactly LAT+1 cycles after acceptance.
    issue(65'd3, 65'd5, 1'b1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("lat_early", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_sum", out_sum, 138'd15);
    chk("lat_count", out_count, 9'd1);
    @(posedge clk);
    #1;
    idle(2);

    // Table of single-term groups.
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].a, tbl[i].b, 1'b1);
      expect_head("tbl", tbl[i].exp_sum, 9'd1, 1'b0);
      idle(2);
    end

    // Four all-ones terms.
    for (int i = 0; i < 4; i++) issue('1, '1, i == 3);
    expect_head("grp4", ones_sq << 2, 9'd4, 1'b0);
    idle(2);

    // Backpressure: two sums fill the buffer, third last waits for credit.
    out_ready = 1'b0;
    issue(65'd1, 65'd10, 1'b1);
    issue(65'd2, 65'd10, 1'b1);
    idle(6);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head_sum", out_sum, 138'd10);
    @(posedge clk);
    #1;
    fork
      issue(65'd3, 65'd10, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_hold_ready", in_ready, 1'b0);
          chk("bp_hold_sum", out_sum, 138'd10);
          chk("bp_hold_count", out_count, 9'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);

    // 257 terms of 1x1 overflows the term count; the following group is clean.
    for (int i = 0; i < 257; i++) issue(65'd1, 65'd1, i == 256);
    expect_head("ovf257", 138'd257, 9'd257, 1'b1);
    idle(2);
    issue(65'd4, 65'd4, 1'b1);
    expect_head("after_ovf", 138'd16, 9'd1, 1'b0);
    idle(2);

    // Reset while two terms are in flight.
    issue(65'd5, 65'd5, 1'b0);
    issue(65'd6, 65'd6, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    issue(65'd7, 65'd9, 1'b1);
    expect_head("mid_rst", 138'd63, 9'd1, 1'b0);
    idle(8);

    // Continuous single-term groups: push and pop coincide.
    for (int i = 0; i < 12; i++) issue(65'(i + 2), 65'd3, 1'b1);
    idle(10);

    // Randomized traffic with random stalls.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 65'({$urandom(), $urandom(), $urandom()});
      rb = 65'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(ra, rb, (i == 299) || ($urandom_range(0, 3) == 0));
    end
    rand_en   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      idle(1);
    end
    idle(3);
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mult65_accum
`default_nettype wire
